gbfofm_port_arbiter: RTL and testbench



---
 rtl/gbfofm_port_arbiter_pkg.sv | 21 ++
 rtl/gbfofm_port_arbiter_if.sv | 43 ++++
 rtl/gbfofm_sat_counter.sv | 29 ++
 rtl/gbfofm_port_arbiter.sv | 139 +++++++++++++
 tb/tb_gbfofm_port_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gbfofm_port_arbiter_pkg.sv
// Purpose : shared encodings for the OFM global-buffer port arbiter.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: FSM state encoding, owner encoding, beat-counter width.
package gbfofm_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_OWN = 2'd1,
    RD_OWN = 2'd2
  } state_e;

  typedef enum logic {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_e;

  // BURST_LEN is limited to 1..15, so 4 bits always hold BURST_LEN-1.
  localparam int BEAT_CNT_W = 4;

endpackage

// File: rtl/gbfofm_port_arbiter_if.sv
// Purpose : bundles the writer, reader, SRAM-wrapper and status signals of the arbiter.
// Latency : n/a (wiring only).
// Backpr. : wr_ready/rd_ready are the only backpressure; read data has none.
// Modports: slave = arbiter view, master = surrounding logic (requesters + SRAM wrapper).
interface gbfofm_port_arbiter_if #(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_WIDTH     = 28,
  parameter int CNT_W          = 16
);
  logic                      wr_valid;
  logic [SRAM_DEPTH_BIT-1:0] wr_addr;
  logic [SRAM_WIDTH-1:0]     wr_data;
  logic                      wr_ready;
  logic                      rd_valid;
  logic [SRAM_DEPTH_BIT-1:0] rd_addr;
  logic                      rd_ready;
  logic                      rd_data_valid;
  logic [SRAM_WIDTH-1:0]     rd_data;
  logic                      mem_read_en;
  logic                      mem_write_en;
  logic [SRAM_DEPTH_BIT-1:0] mem_addr_r;
  logic [SRAM_DEPTH_BIT-1:0] mem_addr_w;
  logic [SRAM_WIDTH-1:0]     mem_data_in;
  logic [SRAM_WIDTH-1:0]     mem_data_out;
  logic                      busy;
  logic [CNT_W-1:0]          stat_conflict;
  logic [CNT_W-1:0]          stat_switch;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_data_out,
    output wr_ready, rd_ready, rd_data_valid, rd_data,
           mem_read_en, mem_write_en, mem_addr_r, mem_addr_w, mem_data_in,
           busy, stat_conflict, stat_switch
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_data_out,
    input  wr_ready, rd_ready, rd_data_valid, rd_data,
           mem_read_en, mem_write_en, mem_addr_r, mem_addr_w, mem_data_in,
           busy, stat_conflict, stat_switch
  );

endinterface

// File: rtl/gbfofm_sat_counter.sv
// Purpose : saturating event counter (sticks at all-ones), synchronous clear.
// Latency : count reflects i_inc one cycle later.
// Backpr. : none.
// Ports   : clk, rst_n (async active-low), i_inc, i_clear, o_count[CNT_W].
module gbfofm_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/gbfofm_port_arbiter.sv
// Purpose : single-port OFM global-buffer scheduler between PE writer and DRAM write-back reader.
// Latency : grant is combinational; rd_data_valid follows an accepted read by one cycle.
// Backpr. : bounded bursts of BURST_LEN beats when contended; reader must sink every data beat.
// Ports   : clk, rst_n (async active-low), io_bus (slave modport: requesters, SRAM wrapper, status).
// Option  : define GBFOFM_ARB_STATS_EN to build the conflict/switch counters; otherwise they read 0.
module gbfofm_port_arbiter
  import gbfofm_port_arbiter_pkg::*;
#(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_WIDTH     = 28,
  parameter int BURST_LEN      = 4,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gbfofm_port_arbiter_if.slave   io_bus
);

  localparam logic [BEAT_CNT_W-1:0] BEAT_MAX = BEAT_CNT_W'(BURST_LEN - 1);

  state_e                  r_state;
  owner_e                  r_last_owner;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;
  logic                    r_busy;
  logic                    r_rd_data_valid;

  logic                    w_gnt_wr;
  logic                    w_gnt_rd;
  logic                    w_burst_done;
  logic                    w_mem_read_en;
  logic [BEAT_CNT_W-1:0]   w_beat_inc;
  logic [SRAM_DEPTH_BIT-1:0] w_addr_w;
  logic [SRAM_DEPTH_BIT-1:0] w_addr_r;
  logic [SRAM_WIDTH-1:0]     w_data_in;

  // The owner has used its full burst once the count reaches BURST_LEN-1;
  // it only yields if the other side is actually waiting.
  assign w_burst_done = (r_beat_cnt == BEAT_MAX);
  assign w_beat_inc   = w_burst_done ? BEAT_MAX : (r_beat_cnt + 1'b1);

  // At most one grant; a dropping owner hands over in the same cycle.
  always_comb begin
    w_gnt_wr = 1'b0;
    w_gnt_rd = 1'b0;
    case (r_state)
      WR_OWN: begin
        if (io_bus.wr_valid && !(io_bus.rd_valid && w_burst_done)) w_gnt_wr = 1'b1;
        else if (io_bus.rd_valid)                                   w_gnt_rd = 1'b1;
      end
      RD_OWN: begin
        if (io_bus.rd_valid && !(io_bus.wr_valid && w_burst_done)) w_gnt_rd = 1'b1;
        else if (io_bus.wr_valid)                                   w_gnt_wr = 1'b1;
      end
      default: begin
        if (io_bus.wr_valid && io_bus.rd_valid) begin
          // Tie from idle alternates against whoever went last.
          if (r_last_owner == OWN_RD) w_gnt_wr = 1'b1;
          else                        w_gnt_rd = 1'b1;
        end else begin
          w_gnt_wr = io_bus.wr_valid;
          w_gnt_rd = io_bus.rd_valid;
        end
      end
    endcase
  end

  assign w_mem_read_en = io_bus.rd_valid & w_gnt_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_last_owner    <= OWN_RD;
      r_beat_cnt      <= '0;
      r_busy          <= 1'b0;
      r_rd_data_valid <= 1'b0;
    end else begin
      r_rd_data_valid <= w_mem_read_en;
      if (w_gnt_wr) begin
        r_state      <= WR_OWN;
        r_last_owner <= OWN_WR;
        r_busy       <= 1'b1;
        r_beat_cnt   <= (r_state == WR_OWN) ? w_beat_inc : '0;
      end else if (w_gnt_rd) begin
        r_state      <= RD_OWN;
        r_last_owner <= OWN_RD;
        r_busy       <= 1'b1;
        r_beat_cnt   <= (r_state == RD_OWN) ? w_beat_inc : '0;
      end else begin
        r_state    <= IDLE;
        r_busy     <= 1'b0;
        r_beat_cnt <= '0;
      end
    end
  end

  assign w_addr_w  = io_bus.wr_addr;
  assign w_addr_r  = io_bus.rd_addr;
  assign w_data_in = io_bus.wr_data;

  assign io_bus.wr_ready      = w_gnt_wr;
  assign io_bus.rd_ready      = w_gnt_rd;
  assign io_bus.mem_write_en  = io_bus.wr_valid & w_gnt_wr;
  assign io_bus.mem_read_en   = w_mem_read_en;
  assign io_bus.mem_addr_w    = w_addr_w;
  assign io_bus.mem_addr_r    = w_addr_r;
  assign io_bus.mem_data_in   = w_data_in;
  assign io_bus.rd_data       = io_bus.mem_data_out;
  assign io_bus.rd_data_valid = r_rd_data_valid;
  assign io_bus.busy          = r_busy;

`ifdef GBFOFM_ARB_STATS_EN
  logic w_conflict;
  logic w_switch;

  assign w_conflict = io_bus.wr_valid & io_bus.rd_valid;
  // Only owner-to-owner handovers count; leaving or entering IDLE does not.
  assign w_switch   = ((r_state == WR_OWN) && w_gnt_rd) || ((r_state == RD_OWN) && w_gnt_wr);

  gbfofm_sat_counter #(.CNT_W(CNT_W)) u_stat_conflict (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_conflict),
    .i_clear (1'b0),
    .o_count (io_bus.stat_conflict)
  );

  gbfofm_sat_counter #(.CNT_W(CNT_W)) u_stat_switch (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_switch),
    .i_clear (1'b0),
    .o_count (io_bus.stat_switch)
  );
`else
  assign io_bus.stat_conflict = {CNT_W{1'b0}};
  assign io_bus.stat_switch   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_gbfofm_port_arbiter.sv
// Purpose : self-checking bench for gbfofm_port_arbiter against a burst-rule reference model.
// Latency : model expects combinational grants and read data one cycle after acceptance.
// Backpr. : bench SRAM answers every read; reader sinks every beat.
module tb_gbfofm_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 28;
  localparam int BL = 4;
  localparam int CW = 16;
`ifdef GBFOFM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gbfofm_port_arbiter_if #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .CNT_W(CW)) bus ();

  gbfofm_port_arbiter #(
    .SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .BURST_LEN(BL), .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Bench-side SRAM wrapper: one access per cycle, registered read data.
  logic [DW-1:0] sram [64];
  always @(posedge clk) begin
    if (bus.mem_write_en)     sram[bus.mem_addr_w] <= bus.mem_data_in;
    else if (bus.mem_read_en) bus.mem_data_out     <= sram[bus.mem_addr_r];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 none, 1 writer, 2 reader. run = consecutive beats given to owner.
  int            m_own, m_run, m_last, m_gnt;
  int            m_conf, m_sw;
  bit            m_rdv;
  logic [DW-1:0] m_rd_exp;
  logic [DW-1:0] m_mem [64];

  function automatic int model_grant(int own, int run, int last, bit wv, bit rv);
    if (own == 1) begin
      if (wv && !(rv && run >= BL)) return 1;
      return rv ? 2 : 0;
    end
    if (own == 2) begin
      if (rv && !(wv && run >= BL)) return 2;
      return wv ? 1 : 0;
    end
    if (wv && rv) return (last == 2) ? 1 : 2;
    if (wv) return 1;
    if (rv) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own <= 0; m_run <= 0; m_last <= 2; m_rdv <= 1'b0;
      m_conf <= 0; m_sw <= 0;
    end else begin
      m_rdv <= (m_gnt == 2);
      if (m_gnt == 2) m_rd_exp <= m_mem[bus.rd_addr];
      if (m_gnt == 1) m_mem[bus.wr_addr] <= bus.wr_data;
      if (bus.wr_valid && bus.rd_valid && m_conf < 65535) m_conf <= m_conf + 1;
      if (((m_own == 1 && m_gnt == 2) || (m_own == 2 && m_gnt == 1)) && m_sw < 65535) m_sw <= m_sw + 1;
      if (m_gnt == 0) begin
        m_own <= 0; m_run <= 0;
      end else if (m_gnt == m_own) begin
        m_run <= m_run + 1;
      end else begin
        m_own <= m_gnt; m_run <= 1;
      end
      if (m_gnt != 0) m_last <= m_gnt;
    end
  end

  always @(negedge clk) begin : compare
    int g;
    if (!rst_n) begin
      m_gnt <= 0;
    end else begin
      g = model_grant(m_own, m_run, m_last, bus.wr_valid, bus.rd_valid);
      m_gnt <= g;
      chk("wr_ready",      32'(bus.wr_ready),      32'(g == 1));
      chk("rd_ready",      32'(bus.rd_ready),      32'(g == 2));
      chk("ready_excl",    32'(bus.wr_ready & bus.rd_ready), 32'(0));
      chk("mem_write_en",  32'(bus.mem_write_en),  32'(g == 1));
      chk("mem_read_en",   32'(bus.mem_read_en),   32'(g == 2));
      chk("mem_addr_w",    32'(bus.mem_addr_w),    32'(bus.wr_addr));
      chk("mem_addr_r",    32'(bus.mem_addr_r),    32'(bus.rd_addr));
      chk("mem_data_in",   32'(bus.mem_data_in),   32'(bus.wr_data));
      chk("busy",          32'(bus.busy),          32'(m_own != 0));
      chk("rd_data_valid", 32'(bus.rd_data_valid), 32'(m_rdv));
      if (m_rdv) chk("rd_data", 32'(bus.rd_data), 32'(m_rd_exp));
      chk("stat_conflict", 32'(bus.stat_conflict), STATS ? 32'(m_conf) : 32'(0));
      chk("stat_switch",   32'(bus.stat_switch),   STATS ? 32'(m_sw)   : 32'(0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    string pat;
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    pat    = "WWWWRRRRWWWW";
    for (int i = 0; i < 64; i++) begin
      sram[i]  = '0;
      m_mem[i] = '0;
    end
    bus.mem_data_out = '0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    idle_inputs();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",     32'(bus.busy), 32'(0));
    chk("rst_rdv",      32'(bus.rd_data_valid), 32'(0));
    chk("rst_stat_sw",  32'(bus.stat_switch), 32'(0));
    #2 rst_n = 1'b1;
    tick();

    // Write-only stream, addr 0..9, data 0x1000+i.
    for (int i = 0; i < 10; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(i);
      bus.wr_data  = DW'(32'h1000 + i);
      @(negedge clk);
      chk("wonly_ready", 32'(bus.wr_ready), 32'(1));
      chk("wonly_wen",   32'(bus.mem_write_en), 32'(1));
      chk("wonly_ren",   32'(bus.mem_read_en), 32'(0));
      tick();
    end
    idle_inputs();
    tick(); tick();

    // Read-only of address 3.
    bus.rd_valid = 1'b1;
    bus.rd_addr  = AW'(3);
    @(negedge clk);
    chk("ronly_ready", 32'(bus.rd_ready), 32'(1));
    tick();
    idle_inputs();
    @(negedge clk);
    chk("ronly_rdv",  32'(bus.rd_data_valid), 32'(1));
    chk("ronly_data", 32'(bus.rd_data), 32'h1003);
    tick(); tick();

    // Continuous contention from IDLE: bursts of BL beats each.
    for (int i = 0; i < 12; i++) begin
      bus.wr_valid = 1'b1; bus.rd_valid = 1'b1;
      bus.wr_addr  = AW'(20 + i); bus.wr_data = DW'(32'h2000 + i);
      bus.rd_addr  = AW'(i % 10);
      @(negedge clk);
      chk("burst_wr", 32'(bus.wr_ready), 32'(pat[i] == "W"));
      chk("burst_rd", 32'(bus.rd_ready), 32'(pat[i] == "R"));
      tick();
    end
    chk("burst_stat_sw",   32'(bus.stat_switch),   STATS ? 32'(2)  : 32'(0));
    chk("burst_stat_conf", 32'(bus.stat_conflict), STATS ? 32'(12) : 32'(0));
    idle_inputs();
    tick(); tick();

    // Writer drops after two beats while reader waits: no bubble.
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(40); bus.wr_data = DW'(32'h3000);
    tick();
    bus.rd_valid = 1'b1; bus.rd_addr = AW'(40); bus.wr_addr = AW'(41);
    @(negedge clk);
    chk("drop_wr_beat2", 32'(bus.wr_ready), 32'(1));
    chk("drop_rd_wait",  32'(bus.rd_ready), 32'(0));
    tick();
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("drop_rd_next", 32'(bus.rd_ready), 32'(1));
    tick();
    idle_inputs();
    tick(); tick();

    // Reset with a read in flight.
    bus.rd_valid = 1'b1; bus.rd_addr = AW'(3);
    tick();
    @(negedge clk);
    chk("inflight_busy", 32'(bus.busy), 32'(1));
    chk("inflight_acc",  32'(bus.rd_ready), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'(0));
    chk("arst_rdv",  32'(bus.rd_data_valid), 32'(0));
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    chk("arst_rdv_after_edge", 32'(bus.rd_data_valid), 32'(0));
    #2 rst_n = 1'b1;
    tick();
    bus.wr_valid = 1'b1; bus.rd_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_tie_wr", 32'(bus.wr_ready), 32'(1));
    chk("post_rst_tie_rd", 32'(bus.rd_ready), 32'(0));
    tick();
    idle_inputs();
    tick();

    // Randomized traffic in phases of different request densities.
    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 70 : (ph == 1) ? 50 : (ph == 2) ? 95 : 20;
      pr = (ph == 0) ? 30 : (ph == 1) ? 50 : (ph == 2) ? 95 : 80;
      for (int c = 0; c < 750; c++) begin
        bus.wr_valid = ($urandom_range(0, 99) < pw);
        bus.rd_valid = ($urandom_range(0, 99) < pr);
        bus.wr_addr  = AW'($urandom_range(0, 63));
        bus.rd_addr  = AW'($urandom_range(0, 63));
        bus.wr_data  = DW'($urandom);
        tick();
      end
    end
    idle_inputs();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
